// File: rtl/cam_capture_scaler.sv
// Camera byte-pair capture: RGB565 -> RGB444/grey, 1:1/2:1/4:1 decimation, linear frame-buffer writes.
// Optional crop window enabled by defining CAPTURE_CROP_EN.
module cam_capture_scaler #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 17,
    parameter int DEPTH    = 76800,
    parameter int CNT_W    = 8,
    parameter int CROP_X0  = 0,
    parameter int CROP_Y0  = 0,
    parameter int CROP_W   = 640,
    parameter int CROP_H   = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              mode,
    input  logic [1:0]        scale,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              overflow,
    output logic              line_err
);

    localparam int COL_W = $clog2(H_ACTIVE + 1) + 1;
    localparam int ROW_W = $clog2(V_ACTIVE + 1) + 1;
    localparam logic [31:0] H_U     = H_ACTIVE;
    localparam logic [31:0] V_U     = V_ACTIVE;
    localparam logic [31:0] DEPTH_U = DEPTH;
`ifdef CAPTURE_CROP_EN
    localparam logic [31:0] X0 = CROP_X0;
    localparam logic [31:0] XW = CROP_W;
    localparam logic [31:0] Y0 = CROP_Y0;
    localparam logic [31:0] YH = CROP_H;
`endif

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    state_t             state_q, state_d;
    logic               vsync_q, href_q;
    logic               phase_q, phase_d;
    logic [7:0]         hi_q, hi_d;
    logic               mode_q, mode_d;
    logic [1:0]         scale_q, scale_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [11:0]        dout_q, dout_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               lerr_q, lerr_d;

    logic        vs_rise, vs_fall, href_fall;
    logic [15:0] pix;
    logic [6:0]  grey_sum;
    logic [11:0] conv;
    logic [31:0] cx, cy, x_off, y_off;
    logic [1:0]  mask;
    logic        in_win, keep;

    always_comb begin
        vs_rise   = vsync & ~vsync_q;
        vs_fall   = ~vsync & vsync_q;
        href_fall = ~href & href_q;
        pix       = {hi_q, d};
        grey_sum  = 7'(pix[15:11]) + 7'(pix[10:5]) + 7'(pix[4:0]);
        conv      = mode_q ? {3{grey_sum[6:3]}} : {pix[15:12], pix[10:7], pix[4:1]};
        cx        = 32'(col_q);
        cy        = 32'(row_q);
`ifdef CAPTURE_CROP_EN
        in_win = (cx >= X0) && (cx < X0 + XW) && (cy >= Y0) && (cy < Y0 + YH);
        x_off  = cx - X0;
        y_off  = cy - Y0;
`else
        in_win = 1'b1;
        x_off  = cx;
        y_off  = cy;
`endif
        case (scale_q)
            2'd0:    mask = 2'b00;
            2'd1:    mask = 2'b01;
            default: mask = 2'b11;
        endcase
        keep = in_win && (cy < V_U) && ((x_off[1:0] & mask) == 2'b00) && ((y_off[1:0] & mask) == 2'b00);
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        mode_d  = mode_q;
        scale_d = scale_q;
        col_d   = col_q;
        row_d   = row_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        lerr_d  = lerr_q;
        case (state_q)
            IDLE: begin
                if (vsync) state_d = SYNC;
            end
            SYNC: begin
                if (vs_fall) begin
                    state_d = ACTIVE;
                    mode_d  = mode;
                    scale_d = (scale == 2'd3) ? 2'd2 : scale;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    ovf_d   = 1'b0;
                    lerr_d  = 1'b0;
                    phase_d = 1'b0;
                end
            end
            ACTIVE: begin
                // Post-write increment never collides with a new pixel: phase1 samples are >= 2 cycles apart.
                if (we_q) addr_d = addr_q + 1'b1;
                if (vs_rise) begin
                    state_d = SYNC;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    phase_d = 1'b0;
                end else if (href) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = d;
                    end else begin
                        if (col_q != '1) col_d = col_q + 1'b1;
                        if (keep) begin
                            if (32'(addr_q) < DEPTH_U) begin
                                we_d   = 1'b1;
                                dout_d = conv;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    phase_d = 1'b0;
                    if (href_fall) begin
                        if (cx != H_U) lerr_d = 1'b1;
                        col_d = '0;
                        if (row_q != '1) row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            hi_q    <= '0;
            mode_q  <= 1'b0;
            scale_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync;
            href_q  <= href;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            mode_q  <= mode_d;
            scale_q <= scale_d;
            col_q   <= col_d;
            row_q   <= row_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            lerr_q  <= lerr_d;
        end
    end

    assign we         = we_q;
    assign addr       = addr_q;
    assign dout       = dout_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;
    assign overflow   = ovf_q;
    assign line_err   = lerr_q;

endmodule

// File: tb/tb_cam_capture_scaler.sv
// Directed frame sequence with random pixel data, checked against an arithmetic capture model.
module tb_cam_capture_scaler;

    localparam int H     = 16;
    localparam int V     = 8;
    localparam int AW    = 8;
    localparam int DEP   = 100;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst, vsync, href, mode;
    logic [7:0]    d;
    logic [1:0]    scale;
    logic          we, frame_done, overflow, line_err;
    logic [AW-1:0] addr;
    logic [11:0]   dout;
    logic [CW-1:0] frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_addr, cnt_m;
    bit ovf_m, lerr_m;

    cam_capture_scaler #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DEPTH(DEP), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .href(href), .d(d),
        .mode(mode), .scale(scale), .we(we), .addr(addr), .dout(dout),
        .frame_done(frame_done), .frame_cnt(frame_cnt),
        .overflow(overflow), .line_err(line_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic vs, input logic hr, input logic [7:0] bt);
        vsync = vs; href = hr; d = bt;
        @(posedge clk);
        #1;
    endtask

    // Reference conversion from the colour-component arithmetic, not bit slicing.
    function automatic int ref_pixel(input bit md, input int p);
        int r5, g6, b5, s;
        r5 = (p >> 11) & 31;
        g6 = (p >> 5) & 63;
        b5 = p & 31;
        if (md) begin
            s = (r5 + g6 + b5) / 8;
            return s * 273;
        end
        return ((r5 / 2) * 256) + ((g6 / 4) * 16) + (b5 / 2);
    endfunction

    task automatic run_frame(input bit md, input logic [1:0] sc, input int nlines, input int short_y,
                             input bit toggle, input bit rnd, input int fixed_pix,
                             input int abort_y, input bit vs_in_line);
        int stride, nb, p, x;
        mode = md; scale = sc;
        repeat (3) step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("flags_clear_at_start", 32'({overflow, line_err}), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        stride = (sc == 2'd0) ? 1 : (sc == 2'd1) ? 2 : 4;
        exp_addr = 0; ovf_m = 1'b0; lerr_m = 1'b0;
        for (int y = 0; y < nlines; y++) begin
            if (y == abort_y) return;
            if (toggle && y == nlines / 2) begin
                mode = ~md; scale = sc + 2'd1;
            end
            nb = (y == short_y) ? 2 * H - 1 : 2 * H;
            for (int b = 0; b < nb; b += 2) begin
                p = rnd ? int'($urandom_range(0, 65535)) : fixed_pix;
                if (vs_in_line && y == nlines - 1 && b == 4) begin
                    step(1'b1, 1'b1, 8'(p >> 8));
                    cnt_m++;
                    chk("done_vs_in_line", 32'(frame_done), 32'd1);
                    chk("we_vs_in_line", 32'(we), 32'd0);
                    chk("cnt_vs_in_line", 32'(frame_cnt), 32'(cnt_m % 16));
                    chk("ovf_vs_in_line", 32'(overflow), 32'(ovf_m));
                    chk("lerr_vs_in_line", 32'(line_err), 32'(lerr_m));
                    step(1'b1, 1'b0, 8'h00);
                    chk("done_pulse_end", 32'(frame_done), 32'd0);
                    return;
                end
                step(1'b0, 1'b1, 8'(p >> 8));
                chk("we_after_hi", 32'(we), 32'd0);
                if (b + 1 < nb) begin
                    step(1'b0, 1'b1, 8'(p & 255));
                    x = b / 2;
                    if (y < V && (x % stride) == 0 && (y % stride) == 0) begin
                        if (exp_addr < DEP) begin
                            chk("we_kept", 32'(we), 32'd1);
                            chk("addr", 32'(addr), 32'(exp_addr));
                            chk("dout", 32'(dout), 32'(ref_pixel(md, p)));
                            exp_addr++;
                        end else begin
                            chk("we_overflow", 32'(we), 32'd0);
                            ovf_m = 1'b1;
                        end
                    end else begin
                        chk("we_dropped", 32'(we), 32'd0);
                    end
                end
            end
            if (nb / 2 != H) lerr_m = 1'b1;
            repeat (3) step(1'b0, 1'b0, 8'h00);
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        cnt_m++;
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("frame_cnt", 32'(frame_cnt), 32'(cnt_m % 16));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("line_err", 32'(line_err), 32'(lerr_m));
        chk("addr_end", 32'(addr), 32'(exp_addr));
        step(1'b1, 1'b0, 8'h00);
        chk("done_pulse", 32'(frame_done), 32'd0);
    endtask

    initial begin
        cnt_m = 0;
        rst = 1'b1; vsync = 1'b0; href = 1'b0; d = '0; mode = 1'b0; scale = '0;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        chk("reset_outputs", 32'({we, addr, dout, frame_done, frame_cnt, overflow, line_err}), 32'd0);
        rst = 1'b0;

        // RGB444, half scale, fixed magenta
        run_frame(1'b0, 2'd1, V, -1, 1'b0, 1'b0, 32'hF81F, -1, 1'b0);
        // grey green, full scale -> overflow; mode/scale toggled mid-frame
        run_frame(1'b1, 2'd0, V, -1, 1'b1, 1'b0, 32'h07E0, -1, 1'b0);
        // random, quarter scale (code 3), short line and lines past V_ACTIVE
        run_frame(1'($urandom_range(0, 1)), 2'd3, V + 2, 3, 1'b0, 1'b1, 0, -1, 1'b0);
        // error flags cleared by the next frame
        run_frame(1'b0, 2'd2, V, -1, 1'b0, 1'b1, 0, -1, 1'b0);
        // vsync rising inside an active line
        run_frame(1'b1, 2'd1, V, -1, 1'b0, 1'b1, 0, -1, 1'b1);

        // Reset mid-frame: partial frame discarded, no capture until a full vsync cycle
        run_frame(1'b0, 2'd0, V, -1, 1'b0, 1'b1, 0, 3, 1'b0);
        rst = 1'b1;
        repeat (2) step(1'b0, 1'b0, 8'h00);
        chk("midframe_reset", 32'({we, addr, dout, frame_done, frame_cnt, overflow, line_err}), 32'd0);
        rst = 1'b0;
        cnt_m = 0;
        for (int b = 0; b < 2 * H; b++) begin
            step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
            if (b % 8 == 7) chk("we_idle_after_reset", 32'(we), 32'd0);
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("no_done_after_reset", 32'(frame_done), 32'd0);
        run_frame(1'b0, 2'd0, 4, -1, 1'b0, 1'b1, 0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
